pc_sequencer: RTL and testbench

Next-PC control for the fetch stage of the five-stage pipeline. This block is the writer for the PC register: it drives that register's `in` and `write_enable` from the PC's current output and the fetched instruction word. It handles:
- boot and interrupt vector loads from instruction memory;
- sequential increment, including two-word (32-bit) instructions;
- stalls and branch redirects from later stages.

---
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC control for the fetch stage. This block drives the PC register's
// input and write enable. It loads the boot and interrupt vectors from
// instruction memory and steps the PC sequentially, keeping the two halves of
// a 32-bit instruction together. It also applies stalls and branch redirects
// from later pipeline stages.
//
// Ports:
//   clk           in   1  clock, rising edge
//   rst           in   1  asynchronous active-low reset
//   pc_cur        in  32  current PC register output
//   mem_data      in  16  instruction word at imem_addr (combinational read)
//   is_two_word   in   1  mem_data is the first half of a 32-bit instruction
//   stall         in   1  hold the PC
//   redirect      in   1  taken branch/jump/return
//   redirect_addr in  32  redirect target
//   int_req       in   1  interrupt request (level or pulse)
//   imem_addr     out 32  instruction memory address
//   pc_next       out 32  PC register input
//   pc_we         out  1  PC register write enable
//   int_ack       out  1  one-cycle pulse on interrupt acceptance
//   epc           out 32  return address captured at acceptance
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [31:0] INT_VEC_ADDR   = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic [15:0] mem_data,
  input  logic        is_two_word,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        int_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        int_ack,
  output logic [31:0] epc
);

  typedef enum logic [2:0] {
    BOOT_HI = 3'd0,
    BOOT_LO = 3'd1,
    RUN     = 3'd2,
    SECOND  = 3'd3,
    INT_HI  = 3'd4,
    INT_LO  = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] vec_hi_reg, vec_hi_next;
  logic [31:0] epc_reg, epc_next;
  logic        int_pending_reg, int_pending_next;
  logic        accept_int;

  // An interrupt is taken only from RUN, never over a redirect or a stall.
  // Accepting only in RUN keeps a 32-bit instruction from being split.
  assign accept_int = (state_reg == RUN) && !redirect && int_pending_reg && !stall;

  assign epc = epc_reg;

  // State register and other sequential state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= BOOT_HI;
      vec_hi_reg      <= 16'd0;
      epc_reg         <= 32'd0;
      int_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      vec_hi_reg      <= vec_hi_next;
      epc_reg         <= epc_next;
      int_pending_reg <= int_pending_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    vec_hi_next = vec_hi_reg;
    epc_next    = epc_reg;
    // A new request on the accept cycle stays pending rather than being lost.
    int_pending_next = int_req | (int_pending_reg & ~accept_int);
    case (state_reg)
      BOOT_HI: begin
        vec_hi_next = mem_data;
        state_next  = BOOT_LO;
      end
      BOOT_LO: state_next = RUN;
      INT_HI: begin
        vec_hi_next = mem_data;
        state_next  = INT_LO;
      end
      INT_LO: state_next = RUN;
      RUN: begin
        if (redirect) begin
          state_next = RUN;
        end else if (accept_int) begin
          epc_next   = pc_cur;
          state_next = INT_HI;
        end else if (stall) begin
          state_next = RUN;
        end else if (is_two_word) begin
          state_next = SECOND;
        end else begin
          state_next = RUN;
        end
      end
      SECOND: begin
        if (redirect || !stall) begin
          state_next = RUN;
        end else begin
          state_next = SECOND;
        end
      end
      default: state_next = BOOT_HI;
    endcase
  end

  // Output logic
  always_comb begin
    imem_addr = pc_cur;
    pc_next   = 32'd0;
    pc_we     = 1'b0;
    int_ack   = 1'b0;
    case (state_reg)
      BOOT_HI: imem_addr = RESET_VEC_ADDR;
      BOOT_LO: begin
        imem_addr = RESET_VEC_ADDR + 32'd1;
        pc_next   = {vec_hi_reg, mem_data};
        pc_we     = 1'b1;
      end
      INT_HI: imem_addr = INT_VEC_ADDR;
      INT_LO: begin
        imem_addr = INT_VEC_ADDR + 32'd1;
        pc_next   = {vec_hi_reg, mem_data};
        pc_we     = 1'b1;
      end
      RUN, SECOND: begin
        imem_addr = pc_cur;
        if (redirect) begin
          pc_next = redirect_addr;
          pc_we   = 1'b1;
        end else if (accept_int) begin
          pc_next = pc_cur;
          int_ack = 1'b1;
        end else if (stall) begin
          pc_next = pc_cur;
        end else begin
          pc_next = pc_cur + 32'd1;
          pc_we   = 1'b1;
        end
      end
      default: imem_addr = RESET_VEC_ADDR;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur;
  logic [15:0] mem_data;
  logic        is_two_word = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'd0;
  logic        int_req = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        int_ack;
  logic [31:0] epc;

  pc_sequencer #(.RESET_VEC_ADDR(32'd0), .INT_VEC_ADDR(32'd2)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .mem_data(mem_data),
    .is_two_word(is_two_word), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .int_req(int_req), .imem_addr(imem_addr),
    .pc_next(pc_next), .pc_we(pc_we), .int_ack(int_ack), .epc(epc)
  );

  always #5 clk = ~clk;

  // Environment: PC register and a small instruction memory.
  logic [31:0] pc_reg = 32'd0;
  always_ff @(posedge clk) if (pc_we) pc_reg <= pc_next;
  assign pc_cur = pc_reg;

  logic [15:0] imem [0:31];
  assign mem_data = imem[imem_addr[4:0]];

  // Reference model: fetch is either loading a vector (two steps from a base
  // address) or fetching instructions, possibly mid-way through a 32-bit one.
  localparam int LOADING = 0, FETCHING = 1;
  int          m_mode, nx_mode;
  int          m_step, nx_step;        // vector word index while loading
  logic [31:0] m_base, nx_base;        // vector base word address
  logic        m_mid, nx_mid;          // second half of a 32-bit instruction due
  logic [15:0] m_hi, nx_hi;
  logic        m_pend, nx_pend;
  logic [31:0] m_epc, nx_epc;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        chk_next;
    logic [31:0] nxt;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic model_reset_next();
    nx_mode = LOADING; nx_step = 0; nx_base = 32'd0; nx_mid = 1'b0;
    nx_hi = 16'd0; nx_pend = 1'b0; nx_epc = 32'd0;
  endtask

  task automatic model_eval(output exp_t e);
    logic [31:0] a;
    e = '0;
    e.rst = rst;
    if (!rst) begin
      model_reset_next();
      m_mode = LOADING; m_step = 0; m_base = 32'd0; m_mid = 1'b0;
      m_hi = 16'd0; m_pend = 1'b0; m_epc = 32'd0;
      e.addr = 32'd0; e.chk_next = 1'b1; e.nxt = 32'd0;
      return;
    end
    nx_mode = m_mode; nx_step = m_step; nx_base = m_base; nx_mid = m_mid;
    nx_hi = m_hi; nx_epc = m_epc;
    nx_pend = m_pend | int_req;
    e.epc = m_epc;
    if (m_mode == LOADING) begin
      a = m_base + m_step;
      e.addr = a;
      if (m_step == 0) begin
        nx_hi = imem[a[4:0]];
        nx_step = 1;
      end else begin
        e.we = 1'b1; e.chk_next = 1'b1;
        e.nxt = {m_hi, imem[a[4:0]]};
        nx_mode = FETCHING; nx_mid = 1'b0;
      end
    end else begin
      e.addr = pc_cur;
      if (redirect) begin
        e.we = 1'b1; e.chk_next = 1'b1; e.nxt = redirect_addr; nx_mid = 1'b0;
      end else if (!m_mid && m_pend && !stall) begin
        e.ack = 1'b1;
        nx_epc = pc_cur;
        nx_pend = int_req;
        nx_mode = LOADING; nx_step = 0; nx_base = 32'd2;
      end else if (!stall) begin
        e.we = 1'b1; e.chk_next = 1'b1; e.nxt = pc_cur + 32'd1;
        nx_mid = m_mid ? 1'b0 : is_two_word;
      end
    end
  endtask

  task automatic drive_cycle(input logic r, input logic st, input logic rd,
                             input logic [31:0] ra, input logic ir, input logic tw);
    exp_t e;
    @(posedge clk);
    #1;
    m_mode = nx_mode; m_step = nx_step; m_base = nx_base; m_mid = nx_mid;
    m_hi = nx_hi; m_pend = nx_pend; m_epc = nx_epc;
    rst = r; stall = st; redirect = rd; redirect_addr = ra;
    int_req = ir; is_two_word = tw;
    #1;
    model_eval(e);
    exp_q.push_back(e);
  endtask

  task automatic quiet();
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT outputs to the expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (pc_we !== e.we) begin
          failures++;
          $display("FAIL pc_we rst=%0b got=%0b exp=%0b pc_cur=%h", e.rst, pc_we, e.we, pc_cur);
        end
        checks++;
        if (imem_addr !== e.addr) begin
          failures++;
          $display("FAIL imem_addr got=%h exp=%h", imem_addr, e.addr);
        end
        checks++;
        if (int_ack !== e.ack) begin
          failures++;
          $display("FAIL int_ack got=%0b exp=%0b", int_ack, e.ack);
        end
        checks++;
        if (epc !== e.epc) begin
          failures++;
          $display("FAIL epc got=%h exp=%h", epc, e.epc);
        end
        if (e.chk_next) begin
          checks++;
          if (pc_next !== e.nxt) begin
            failures++;
            $display("FAIL pc_next got=%h exp=%h pc_cur=%h", pc_next, e.nxt, pc_cur);
          end
        end
        $display("cyc rst=%0b we=%0b next=%h addr=%h ack=%0b epc=%h", e.rst, pc_we, pc_next, imem_addr, int_ack, epc);
      end
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h0000; imem[1] = 16'h0020;
    imem[2] = 16'h0000; imem[3] = 16'h0200;
    model_reset_next();

    // Reset, then boot.
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);   // BOOT_HI ignores these
    quiet();                                             // BOOT_LO -> 0x20
    // Two-word instruction at 0x20; second word's flag is ignored.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    quiet();
    // Stall, then stall with redirect.
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    // Interrupt at PC 0x30 while stalled, then run through the vector load.
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (5) quiet();
    // Interrupt pulse in SECOND is deferred.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (5) quiet();
    // Wrap-around.
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    quiet();
    quiet();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'b1,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) < 2));
    end

    // Reset during the low-half interrupt vector fetch.
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (nx_mode == LOADING && nx_step == 1 && nx_base == 32'd2) begin
        found = 1'b1;
        break;
      end
      quiet();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_int_lo got=not_reached exp=reached");
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (6) quiet();

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
